// File: rtl/nibble_pkg.sv
// Shared widths, FSM state type and counter-width helper for the nibble assembler.
package nibble_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_FIRST,
        S_SECOND,
        S_FULL
    } nib_state_e;

    function automatic int unsigned cnt_width(input int unsigned frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/nibble_byte_if.sv
// Nibble-sliced byte bus: two producer modports each own one half of x.
interface nibble_byte_if;
    import nibble_pkg::*;

    logic [NIB_W-1:0]  p1;
    logic [NIB_W-1:0]  p2;
    logic [BYTE_W-1:0] x;

    assign x = {p2, p1};

    modport lo   (output p1);
    modport hi   (output p2);
    modport sink (input x);

endinterface

// File: rtl/nib_frame_counter.sv
// Wrapping byte-per-frame counter with a terminal-count decode.
module nib_frame_counter
    import nibble_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic i_clk,
    input  logic i_arst_n,
    input  logic i_inc,
    output logic o_last
);

    localparam int unsigned     CW   = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0]   LAST = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_last = (cnt_q == LAST);

endmodule

// File: rtl/nibble_assembler.sv
// Pairs a valid/ready nibble stream into bytes written as two halves of a shared bus.
module nibble_assembler
    import nibble_pkg::*;
#(
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    nibble_byte_if.lo        lo,
    nibble_byte_if.hi        hi,
    input  logic [NIB_W-1:0] i_nib,
    input  logic             i_nib_valid,
    output logic             o_nib_ready,
    output logic             o_byte_valid,
    input  logic             i_byte_ready,
    output logic             o_last
);

    nib_state_e state_q;
    nib_state_e state_d;
    logic       run_q;
    logic       nib_hs;
    logic       byte_hs;
    logic       wr_first;
    logic       wr_second;
    logic       wr_lo;
    logic       wr_hi;

    // run_q keeps o_nib_ready low until the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= S_FIRST;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FIRST:  if (nib_hs) state_d = S_SECOND;
            S_SECOND: if (nib_hs) state_d = S_FULL;
            S_FULL:   if (byte_hs) state_d = nib_hs ? S_SECOND : S_FIRST;
            default:  state_d = S_FIRST;
        endcase
    end

    // In S_FULL a nibble is only taken when the held byte leaves the same cycle.
    always_comb begin
        o_byte_valid = (state_q == S_FULL);
        o_nib_ready  = run_q && ((state_q != S_FULL) || i_byte_ready);
        nib_hs       = i_nib_valid && o_nib_ready;
        byte_hs      = o_byte_valid && i_byte_ready;
        wr_first     = nib_hs && (state_q != S_SECOND);
        wr_second    = nib_hs && (state_q == S_SECOND);
        wr_lo        = LSB_FIRST ? wr_first : wr_second;
        wr_hi        = LSB_FIRST ? wr_second : wr_first;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            lo.p1 <= '0;
        end else if (wr_lo) begin
            lo.p1 <= i_nib;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            hi.p2 <= '0;
        end else if (wr_hi) begin
            hi.p2 <= i_nib;
        end
    end

    nib_frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_inc    (byte_hs),
        .o_last   (o_last)
    );

endmodule

// File: doc/nibble_assembler.md
# nibble_assembler

Upstream producer for the nibble-sliced byte interface. Accepts a 4-bit nibble stream under valid/ready handshake, pairs consecutive nibbles into a byte, and writes the two halves through two generic interface ports that bind to the low-nibble modport expression (`p1`, `x[3:0]`) and the high-nibble modport expression (`p2`, `x[7:4]`) of one interface instance. The full `x` is consumed downstream under a byte valid/ready handshake, with byte framing.

## Interface
- `LSB_FIRST`, default 1: 1 means the first nibble of a pair goes to `p1` (low) and the second to `p2` (high). 0 reverses the order.
- `FRAME_LEN`, default 4: bytes per frame. Legal range 1..255.
- `i_clk`  input  1  single clock. All state changes on the rising edge.
- `i_arst_n`  input  1  reset, asynchronous and active-low.
- `lo`  interface  generic  bound to a modport exposing output `p1` [3:0] (low nibble slice).
- `hi`  interface  generic  bound to a modport exposing output `p2` [3:0] (high nibble slice).
- `i_nib`  input  4  nibble data.
- `i_nib_valid`  input  1  nibble present.
- `o_nib_ready`  output  1  block can accept a nibble.
- `o_byte_valid`  output  1  `lo.p1`/`hi.p2` hold a complete byte.
- `i_byte_ready`  input  1  downstream takes the byte.
- `o_last`  output  1  the presented byte is the last byte of its frame. Qualified by `o_byte_valid`.

## Operation
- States: `S_FIRST` (waiting for the first nibble), `S_SECOND` (waiting for the second nibble), `S_FULL` (byte presented).
- Nibble handshake occurs when `i_nib_valid && o_nib_ready` at a clock edge. Byte handshake occurs when `o_byte_valid && i_byte_ready`.
- Write target:
  - first nibble goes to `p1` if `LSB_FIRST`, otherwise to `p2`.
  - second nibble goes to the other half.
- The untouched half holds its value.
- `S_FIRST`:
  - `o_nib_ready = 1`.
  - On a nibble handshake: write the first half, then go to `S_SECOND`.
- `S_SECOND`:
  - `o_nib_ready = 1`.
  - On a nibble handshake: write the second half, then go to `S_FULL`.
- `S_FULL`:
  - `o_byte_valid = 1` and `o_nib_ready = i_byte_ready`. This is a deliberate combinational pass-through.
  - Byte handshake with a simultaneous nibble handshake: write the first half of the next byte, then go to `S_SECOND`.
  - Byte handshake alone: go to `S_FIRST`.
  - No byte handshake: hold. Both halves must stay stable while `o_byte_valid` is high.
- Frame counter `cnt`, range 0..`FRAME_LEN-1`:
  - Increments on each byte handshake and wraps to 0 after `FRAME_LEN-1`.
  - `o_last = (cnt == FRAME_LEN-1)`.
  - With `FRAME_LEN` = 1, `o_last` is constantly 1.
- `i_nib` is ignored when there is no nibble handshake.
- Data is never dropped or duplicated.

## Timing
- Reset asserted: `p1 = 0`, `p2 = 0`, state `S_FIRST`, `cnt = 0`, `o_byte_valid = 0`, `o_last = 0` (`FRAME_LEN` = 1: `o_last = 1`), `o_nib_ready = 0`.
- `o_nib_ready` rises at the first clock edge after `i_arst_n` deasserts.
- Latency: `o_byte_valid` rises the cycle after the second nibble handshake.
- Sustained throughput is one byte per 2 cycles with `i_byte_ready` tied high.
- `o_byte_valid`, `o_last`, `p1` and `p2` are registered or decoded from registers only. `o_nib_ready` depends combinationally on `i_byte_ready` in `S_FULL` only.
- Reset mid-operation: any partial nibble pair or held byte is discarded and `cnt` clears. No byte handshake can complete during reset.
- Backpressure in `S_FULL`: data, `o_last` and `cnt` stay frozen for any number of cycles.

## Structure
- Package `nibble_pkg` holds:
  - `NIB_W` = 4 and `BYTE_W` = 8;
  - the state enum `nib_state_e {S_FIRST, S_SECOND, S_FULL}`;
  - the localparam helper for the counter width `$clog2(FRAME_LEN)` (minimum 1).
- Sub-module `nib_frame_counter` has parameter `FRAME_LEN` and ports `i_clk`, `i_arst_n`, `i_inc`, `o_last`. It is the natural split: a wrapping counter with a terminal-count decode.
- Writes to `lo.p1`/`hi.p2` use `always_ff` with asynchronous reset. Each interface port is driven from exactly one process.

## Test plan
- Reset with nibbles 0x3 then 0xA, `i_byte_ready = 1`, `LSB_FIRST = 1` -> byte 0xA3 presented 1 cycle after the second handshake; `o_last = 0`.
- `LSB_FIRST = 0`, nibbles 0x3 then 0xA -> byte 0x3A.
- Streaming 8 nibbles back-to-back, `FRAME_LEN = 4`, ready held high -> 4 bytes at 2-cycle spacing; `o_last` is high on the 4th byte only and `cnt` wraps to 0.
- Byte 0x5C presented with `i_byte_ready` low for 5 cycles while a nibble 0x7 is offered -> `o_nib_ready = 0`, byte stable. Ready rises -> 0x5C and 0x7 accepted in the same cycle, state `S_SECOND`.
- `i_arst_n` pulsed low in `S_SECOND` after nibble 0xF -> halves are 0, `o_byte_valid = 0`. The next pair 0x1, 0x2 yields 0x21 with `cnt` restarted at 0.
- `FRAME_LEN = 1` -> `o_last = 1` on every byte; the counter never leaves 0.
